pll_speed_seq: RTL and testbench

Reconfiguration sequencer that sits directly upstream of the PLL reconfiguration controller (pll_cfg) in the Gyruss core. It watches the OSD "Game Speed" request (Native / 60Hz Adjust), synchronises and debounces it, then issues the three-write Avalon-MM sequence that retunes the video/system PLL fractional divider: mode, fraction, start. It optionally waits for PLL re-lock and reports busy/done/error status to the top level.

---
 rtl/pll_speed_seq_pkg.sv | 24 ++
 rtl/pll_speed_seq_if.sv | 23 ++
 rtl/pll_speed_seq_req_filter.sv | 42 ++++
 rtl/pll_speed_seq.sv | 193 +++++++++++++++++++
 tb/tb_pll_speed_seq.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_speed_seq_pkg.sv
// Shared types and constants for the PLL speed sequencer: FSM states, pll_cfg word
// addresses and the default fractional-divider words.
package pll_speed_pkg;

    typedef enum logic [3:0] {
        IDLE,
        W_MODE,
        GAP_A,
        W_FRAC,
        GAP_B,
        W_START,
        LOCK_LO,
        LOCK_HI,
        FIN
    } seq_state_t;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_FRAC  = 6'd7;

    localparam logic [31:0] FRAC_NATIVE_DEF = 32'd3639383488;
    localparam logic [31:0] FRAC_UNDER_DEF  = 32'd3262113561;

endpackage

// File: rtl/pll_speed_seq_if.sv
// Avalon-MM write-only management port between the speed sequencer and pll_cfg.
interface pll_speed_seq_if;

    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_write,
        output mgmt_address,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_write,
        input  mgmt_address,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );

endinterface

// File: rtl/pll_speed_seq_req_filter.sv
// Two-flop synchroniser plus debounce: filt_val follows the input only after
// FILT_CYCLES consecutive synchronised samples that disagree with it.
module pll_req_filter #(
    parameter int FILT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic filt_val
);

    localparam int CW = $clog2(FILT_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          filt_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            filt_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= async_in;
            sync2_reg <= sync1_reg;
            // Any sample agreeing with the current value restarts the run.
            if (sync2_reg == filt_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg >= CW'(FILT_CYCLES - 1)) begin
                filt_reg <= sync2_reg;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign filt_val = filt_reg;

endmodule

// File: rtl/pll_speed_seq.sv
// Game-speed PLL retune sequencer: writes mode, fraction, start to pll_cfg on a request change.
// Define PLL_SPEED_LOCKWAIT_EN to add the lock-loss/re-lock wait and lock_err reporting.
module pll_speed_seq
    import pll_speed_pkg::*;
#(
    parameter logic [31:0] FRAC_NATIVE  = FRAC_NATIVE_DEF,
    parameter logic [31:0] FRAC_UNDER   = FRAC_UNDER_DEF,
    parameter int          FILT_CYCLES  = 16,
    parameter int          GAP_CYCLES   = 3,
    parameter int          LOCK_TIMEOUT = 1048576
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            underclock_req,
    input  logic            pll_locked,
    pll_speed_seq_if.master mgmt,
    output logic            applied,
    output logic            busy,
    output logic            done,
    output logic            lock_err
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    seq_state_t    state_reg, state_next;
    logic          target_reg, target_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic          gap_done;

    logic          write_reg, write_next;
    logic [5:0]    addr_reg, addr_next;
    logic [31:0]   data_reg, data_next;
    logic          applied_reg, applied_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic          filt_val;
    logic          lo_go;
    logic          hi_go;
    logic          run_err;
    logic          lock_err_reg;
    logic          fin_exit;

    pll_req_filter #(
        .FILT_CYCLES (FILT_CYCLES)
    ) u_req_filter (
        .clk      (clk),
        .reset    (reset),
        .async_in (underclock_req),
        .filt_val (filt_val)
    );

`ifdef PLL_SPEED_LOCKWAIT_EN
    localparam seq_state_t POST_START = LOCK_LO;
    localparam int         TW         = $clog2(LOCK_TIMEOUT + 1);

    logic [1:0]    lock_sync_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic          tmo_done;
    logic          err_run_reg;

    assign tmo_done = tmo_cnt_reg >= TW'(LOCK_TIMEOUT - 1);
    // A missed lock drop is tolerated; only a failure to re-lock is an error.
    assign lo_go    = !lock_sync_reg[1] || tmo_done;
    assign hi_go    = lock_sync_reg[1] || tmo_done;
    assign run_err  = err_run_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_sync_reg <= 2'b00;
            tmo_cnt_reg   <= '0;
            err_run_reg   <= 1'b0;
            lock_err_reg  <= 1'b0;
        end else begin
            lock_sync_reg <= {lock_sync_reg[0], pll_locked};
            if (state_next != state_reg) begin
                tmo_cnt_reg <= '0;
            end else if (!tmo_done) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
            if (state_reg == IDLE && state_next == W_MODE) begin
                err_run_reg <= 1'b0;
            end else if (state_reg == LOCK_HI && state_next == FIN && !lock_sync_reg[1]) begin
                err_run_reg  <= 1'b1;
                lock_err_reg <= 1'b1;
            end
        end
    end
`else
    localparam seq_state_t POST_START = FIN;

    logic lock_unused;

    assign lock_unused  = pll_locked;
    assign lo_go        = 1'b1;
    assign hi_go        = 1'b1;
    assign run_err      = 1'b0;
    assign lock_err_reg = 1'b0;
`endif

    assign gap_done = gap_cnt_reg >= GW'(GAP_CYCLES - 1);
    assign fin_exit = (state_reg == FIN) && (state_next == IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            target_reg  <= 1'b0;
            gap_cnt_reg <= '0;
            write_reg   <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            applied_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            target_reg  <= target_next;
            gap_cnt_reg <= gap_cnt_next;
            write_reg   <= write_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            applied_reg <= applied_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        case (state_reg)
            IDLE: begin
                if (filt_val != applied_reg) begin
                    state_next  = W_MODE;
                    target_next = filt_val;
                end
            end
            W_MODE:  if (!mgmt.mgmt_waitrequest) state_next = GAP_A;
            GAP_A:   if (gap_done) state_next = W_FRAC;
            W_FRAC:  if (!mgmt.mgmt_waitrequest) state_next = GAP_B;
            GAP_B:   if (gap_done) state_next = W_START;
            W_START: if (!mgmt.mgmt_waitrequest) state_next = POST_START;
            LOCK_LO: if (gap_done && lo_go) state_next = LOCK_HI;
            LOCK_HI: if (hi_go) state_next = FIN;
            // FIN only carries the post-write gap when it directly follows W_START.
            FIN:     if (POST_START != FIN || gap_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        gap_cnt_next = gap_cnt_reg;
        if (state_next != state_reg) begin
            gap_cnt_next = '0;
        end else if (!gap_done) begin
            gap_cnt_next = gap_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        write_next = 1'b0;
        addr_next  = addr_reg;
        data_next  = data_reg;
        case (state_next)
            W_MODE: begin
                write_next = 1'b1;
                addr_next  = ADDR_MODE;
                data_next  = 32'd0;
            end
            W_FRAC: begin
                write_next = 1'b1;
                addr_next  = ADDR_FRAC;
                data_next  = target_reg ? FRAC_UNDER : FRAC_NATIVE;
            end
            W_START: begin
                write_next = 1'b1;
                addr_next  = ADDR_START;
                data_next  = 32'd0;
            end
            default: ;
        endcase
        busy_next    = (state_next != IDLE);
        done_next    = fin_exit && !run_err;
        applied_next = fin_exit ? target_reg : applied_reg;
    end

    assign mgmt.mgmt_write     = write_reg;
    assign mgmt.mgmt_address   = addr_reg;
    assign mgmt.mgmt_writedata = data_reg;
    assign applied             = applied_reg;
    assign busy                = busy_reg;
    assign done                = done_reg;
    assign lock_err            = lock_err_reg;

endmodule

// File: tb/tb_pll_speed_seq.sv
// Directed bench for pll_speed_seq: reset, both speed runs, waitrequest stall, short
// request pulse, lock-wait timeouts (build-dependent expectations) and mid-run reset.
module tb_pll_speed_seq;

    localparam logic [31:0] F_NAT = 32'd3639383488;
    localparam logic [31:0] F_UND = 32'd3262113561;
`ifdef PLL_SPEED_LOCKWAIT_EN
    localparam bit LOCKWAIT = 1'b1;
`else
    localparam bit LOCKWAIT = 1'b0;
`endif

    logic clk;
    logic reset;
    logic underclock_req;
    logic lock_model;
    logic lock_force_en;
    logic lock_force_val;
    logic pll_locked;
    logic applied;
    logic busy;
    logic done;
    logic lock_err;

    assign pll_locked = lock_force_en ? lock_force_val : lock_model;

    pll_speed_seq_if mgmt_bus ();

    pll_speed_seq #(
        .LOCK_TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .underclock_req (underclock_req),
        .pll_locked     (pll_locked),
        .mgmt           (mgmt_bus.master),
        .applied        (applied),
        .busy           (busy),
        .done           (done),
        .lock_err       (lock_err)
    );

    int total;
    int bad;
    int wr_count;
    int done_count;
    int strobe_count;
    logic [5:0]  log_addr [256];
    logic [31:0] log_data [256];

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Transaction monitor, sampled mid-cycle.
    initial begin
        wr_count     = 0;
        done_count   = 0;
        strobe_count = 0;
        forever begin
            @(negedge clk);
            if (mgmt_bus.mgmt_write) strobe_count++;
            if (mgmt_bus.mgmt_write && !mgmt_bus.mgmt_waitrequest) begin
                log_addr[wr_count & 255] = mgmt_bus.mgmt_address;
                log_data[wr_count & 255] = mgmt_bus.mgmt_writedata;
                $display("write %0d: addr=%0d data=%0d", wr_count, mgmt_bus.mgmt_address, mgmt_bus.mgmt_writedata);
                wr_count++;
            end
            if (done) done_count++;
        end
    end

    // PLL model: loses lock shortly after the start write, re-locks 10 cycles later.
    initial begin
        lock_model = 1'b1;
        forever begin
            @(negedge clk);
            if (mgmt_bus.mgmt_write && !mgmt_bus.mgmt_waitrequest && mgmt_bus.mgmt_address == 6'd2) begin
                repeat (4) @(posedge clk);
                #1 lock_model = 1'b0;
                repeat (10) @(posedge clk);
                #1 lock_model = 1'b1;
            end
        end
    end

    task automatic wait_run(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            n = 0;
            while (busy && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            ok = !busy;
        end
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset          = 1'b0;
        underclock_req = 1'b0;
        lock_force_en  = 1'b0;
        lock_force_val = 1'b0;
        mgmt_bus.mgmt_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (mgmt_bus.mgmt_write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b want=0", mgmt_bus.mgmt_write); end
        total++; if (mgmt_bus.mgmt_address !== 6'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", mgmt_bus.mgmt_address); end
        total++; if (mgmt_bus.mgmt_writedata !== 32'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", mgmt_bus.mgmt_writedata); end
        total++; if (applied !== 1'b0) begin bad++; $display("FAIL reset_applied got=%b want=0", applied); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (lock_err !== 1'b0) begin bad++; $display("FAIL reset_lock_err got=%b want=0", lock_err); end
    endtask

    task automatic test_underclock_run;
        int first, base, dbase;
        bit ok;
        logic [5:0]  ea [3];
        logic [31:0] ed [3];
        ea[0] = 6'd0; ed[0] = 32'd0;
        ea[1] = 6'd7; ed[1] = F_UND;
        ea[2] = 6'd2; ed[2] = 32'd0;
        base = wr_count; dbase = done_count; first = 0;
        underclock_req = 1'b1;
        reset = 1'b1;
        for (int c = 1; c <= 60 && first == 0; c++) begin
            @(posedge clk); #1;
            if (mgmt_bus.mgmt_write === 1'b1) first = c;
        end
        total++; if (first != 19) begin bad++; $display("FAIL first_write_cycle got=%0d want=19", first); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_run got=%b want=1", busy); end
        wait_run(ok);
        total++; if (!ok) begin bad++; $display("FAIL under_run_timeout got=%0d want=1", ok); end
        total++; if (wr_count - base != 3) begin bad++; $display("FAIL under_wr_count got=%0d want=3", wr_count - base); end
        for (int i = 0; i < 3; i++) begin
            total++; if (log_addr[(base + i) & 255] !== ea[i]) begin bad++; $display("FAIL under_addr%0d got=%0d want=%0d", i, log_addr[(base + i) & 255], ea[i]); end
            total++; if (log_data[(base + i) & 255] !== ed[i]) begin bad++; $display("FAIL under_data%0d got=%0d want=%0d", i, log_data[(base + i) & 255], ed[i]); end
        end
        total++; if (done_count - dbase != 1) begin bad++; $display("FAIL under_done_cycles got=%0d want=1", done_count - dbase); end
        total++; if (applied !== 1'b1) begin bad++; $display("FAIL under_applied got=%b want=1", applied); end
        total++; if (lock_err !== 1'b0) begin bad++; $display("FAIL under_lock_err got=%b want=0", lock_err); end
    endtask

    task automatic test_native_run;
        int base, dbase;
        bit ok;
        base = wr_count; dbase = done_count;
        underclock_req = 1'b0;
        wait_run(ok);
        total++; if (!ok) begin bad++; $display("FAIL native_run_timeout got=%0d want=1", ok); end
        total++; if (wr_count - base != 3) begin bad++; $display("FAIL native_wr_count got=%0d want=3", wr_count - base); end
        total++; if (log_addr[(base + 1) & 255] !== 6'd7) begin bad++; $display("FAIL native_frac_addr got=%0d want=7", log_addr[(base + 1) & 255]); end
        total++; if (log_data[(base + 1) & 255] !== F_NAT) begin bad++; $display("FAIL native_frac_data got=%0d want=%0d", log_data[(base + 1) & 255], F_NAT); end
        total++; if (log_addr[(base + 2) & 255] !== 6'd2) begin bad++; $display("FAIL native_start_addr got=%0d want=2", log_addr[(base + 2) & 255]); end
        total++; if (done_count - dbase != 1) begin bad++; $display("FAIL native_done_cycles got=%0d want=1", done_count - dbase); end
        total++; if (applied !== 1'b0) begin bad++; $display("FAIL native_applied got=%b want=0", applied); end
    endtask

    task automatic test_waitrequest;
        int base, n;
        bit ok, hold_ok;
        base = wr_count;
        underclock_req = 1'b1;
        n = 0;
        while (!(busy && !mgmt_bus.mgmt_write && wr_count == base + 1) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (n >= 100) begin bad++; $display("FAIL wreq_gap_a_seen got=%0d want<100", n); end
        mgmt_bus.mgmt_waitrequest = 1'b1;
        n = 0;
        while (!(mgmt_bus.mgmt_write && mgmt_bus.mgmt_address == 6'd7) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (n >= 20) begin bad++; $display("FAIL wreq_frac_seen got=%0d want<20", n); end
        hold_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (mgmt_bus.mgmt_write !== 1'b1 || mgmt_bus.mgmt_address !== 6'd7 || mgmt_bus.mgmt_writedata !== F_UND) hold_ok = 1'b0;
        end
        total++; if (!hold_ok) begin bad++; $display("FAIL wreq_hold got=%0d want=1", hold_ok); end
        mgmt_bus.mgmt_waitrequest = 1'b0;
        @(posedge clk); #1;
        total++; if (mgmt_bus.mgmt_write !== 1'b0) begin bad++; $display("FAIL wreq_release_drop got=%b want=0", mgmt_bus.mgmt_write); end
        wait_run(ok);
        total++; if (!ok) begin bad++; $display("FAIL wreq_run_timeout got=%0d want=1", ok); end
        total++; if (wr_count - base != 3) begin bad++; $display("FAIL wreq_wr_count got=%0d want=3", wr_count - base); end
        total++; if (applied !== 1'b1) begin bad++; $display("FAIL wreq_applied got=%b want=1", applied); end
    endtask

    task automatic test_short_pulse;
        int sbase;
        sbase = strobe_count;
        underclock_req = 1'b0;
        repeat (10) @(posedge clk);
        #1 underclock_req = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        total++; if (strobe_count - sbase != 0) begin bad++; $display("FAIL pulse_strobes got=%0d want=0", strobe_count - sbase); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pulse_busy got=%b want=0", busy); end
        total++; if (applied !== 1'b1) begin bad++; $display("FAIL pulse_applied got=%b want=1", applied); end
    endtask

    task automatic test_lock_timeouts;
        int dbase;
        bit ok;
        bit exp_done, exp_err;
        exp_done = !LOCKWAIT;
        exp_err  = LOCKWAIT;
        lock_force_en  = 1'b1;
        lock_force_val = 1'b1;
        dbase = done_count;
        underclock_req = 1'b0;
        wait_run(ok);
        total++; if (!ok) begin bad++; $display("FAIL stuck1_timeout got=%0d want=1", ok); end
        total++; if (done_count - dbase != 1) begin bad++; $display("FAIL stuck1_done got=%0d want=1", done_count - dbase); end
        total++; if (lock_err !== 1'b0) begin bad++; $display("FAIL stuck1_lock_err got=%b want=0", lock_err); end
        total++; if (applied !== 1'b0) begin bad++; $display("FAIL stuck1_applied got=%b want=0", applied); end
        lock_force_val = 1'b0;
        dbase = done_count;
        underclock_req = 1'b1;
        wait_run(ok);
        total++; if (!ok) begin bad++; $display("FAIL stuck0_timeout got=%0d want=1", ok); end
        total++; if (done_count - dbase != int'(exp_done)) begin bad++; $display("FAIL stuck0_done got=%0d want=%0d", done_count - dbase, exp_done); end
        total++; if (lock_err !== exp_err) begin bad++; $display("FAIL stuck0_lock_err got=%b want=%b", lock_err, exp_err); end
        total++; if (applied !== 1'b1) begin bad++; $display("FAIL stuck0_applied got=%b want=1", applied); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stuck0_busy got=%b want=0", busy); end
        lock_force_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        int base, n, first;
        bit ok;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (lock_err !== 1'b0) begin bad++; $display("FAIL mid_pre_lock_err got=%b want=0", lock_err); end
        reset = 1'b1;
        base = wr_count;
        n = 0;
        while (wr_count != base + 2 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (n >= 200) begin bad++; $display("FAIL mid_gap_b_seen got=%0d want<200", n); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (mgmt_bus.mgmt_write !== 1'b0) begin bad++; $display("FAIL mid_write got=%b want=0", mgmt_bus.mgmt_write); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        total++; if (applied !== 1'b0) begin bad++; $display("FAIL mid_applied got=%b want=0", applied); end
        reset = 1'b1;
        base = wr_count;
        first = 0;
        for (int c = 1; c <= 60 && first == 0; c++) begin
            @(posedge clk); #1;
            if (mgmt_bus.mgmt_write === 1'b1) first = c;
        end
        total++; if (first != 19) begin bad++; $display("FAIL mid_restart_cycle got=%0d want=19", first); end
        total++; if (mgmt_bus.mgmt_address !== 6'd0) begin bad++; $display("FAIL mid_restart_addr got=%0d want=0", mgmt_bus.mgmt_address); end
        wait_run(ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_run_timeout got=%0d want=1", ok); end
        total++; if (wr_count - base != 3) begin bad++; $display("FAIL mid_wr_count got=%0d want=3", wr_count - base); end
        total++; if (log_data[(base + 1) & 255] !== F_UND) begin bad++; $display("FAIL mid_frac_data got=%0d want=%0d", log_data[(base + 1) & 255], F_UND); end
        total++; if (applied !== 1'b1) begin bad++; $display("FAIL mid_applied_after got=%b want=1", applied); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_underclock_run();
        test_native_run();
        test_waitrequest();
        test_short_pulse();
        test_lock_timeouts();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
